// File: rtl/button_event_decoder_if.sv
// Button level in, classified event pulses and the long-press hold level out.
// The decoder takes the slave side and the producer/consumer takes the master side.
interface button_event_decoder_if;
    logic level;
    logic short_press;
    logic long_press;
    logic double_click;
    logic held;

    modport master (
        output level,
        input  short_press,
        input  long_press,
        input  double_click,
        input  held
    );

    modport slave (
        input  level,
        output short_press,
        output long_press,
        output double_click,
        output held
    );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies debounced button presses as short, long or double click. Every output is registered.
// Define BTN_DCLICK_EN to build double-click detection: a release then waits in a gap window.
module button_event_decoder #(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DCLICK_MS = 300
) (
    input  logic                  clk,
    input  logic                  rst_n,
    button_event_decoder_if.slave btn
);
    localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned EL_MAX = (LONG_MS > DCLICK_MS) ? LONG_MS : DCLICK_MS;
    localparam int unsigned EL_W   = $clog2(EL_MAX + 1);

    typedef enum logic [2:0] {
        LOCKOUT   = 3'd0,
        IDLE      = 3'd1,
        PRESSED   = 3'd2,
        LONG_HELD = 3'd3,
        GAP       = 3'd4,
        SECOND    = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [EL_W-1:0]  elapsed_q, elapsed_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             dbl_q, dbl_d;
    logic             held_q, held_d;

    logic             tick;
    logic             timed;
    logic [EL_W-1:0]  el_inc;

    // State, timers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOCKOUT;
            pre_q     <= '0;
            elapsed_q <= '0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            dbl_q     <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            elapsed_q <= elapsed_d;
            short_q   <= short_d;
            long_q    <= long_d;
            dbl_q     <= dbl_d;
            held_q    <= held_d;
        end
    end

    // Next state, event decode and timer update
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        elapsed_d = elapsed_q;
        short_d   = 1'b0;
        long_d    = 1'b0;
        dbl_d     = 1'b0;
        tick      = (pre_q == PRE_W'(TICK_DIV - 1));
        el_inc    = elapsed_q + EL_W'(1);
        timed     = (state_q == PRESSED);
`ifdef BTN_DCLICK_EN
        timed     = (state_q == PRESSED) || (state_q == GAP);
`endif

        case (state_q)
            LOCKOUT: if (!btn.level) state_d = IDLE;
            IDLE:    if (btn.level)  state_d = PRESSED;
            PRESSED: begin
                // Release is checked first so it wins a tie with the final tick
                if (!btn.level) begin
`ifdef BTN_DCLICK_EN
                    state_d = GAP;
`else
                    short_d = 1'b1;
                    state_d = IDLE;
`endif
                end else if (tick && (el_inc == EL_W'(LONG_MS))) begin
                    long_d  = 1'b1;
                    state_d = LONG_HELD;
                end
            end
            LONG_HELD: if (!btn.level) state_d = IDLE;
`ifdef BTN_DCLICK_EN
            GAP: begin
                // A press wins a tie with the window timeout
                if (btn.level) begin
                    dbl_d   = 1'b1;
                    state_d = SECOND;
                end else if (tick && (el_inc == EL_W'(DCLICK_MS))) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end
            end
            SECOND: if (!btn.level) state_d = IDLE;
`endif
            default: state_d = LOCKOUT;
        endcase

        // Durations are measured from state entry; untimed states keep the timers cleared
        if ((state_d != state_q) || !timed) begin
            pre_d     = '0;
            elapsed_d = '0;
        end else if (tick) begin
            pre_d     = '0;
            elapsed_d = el_inc;
        end else begin
            pre_d     = pre_q + PRE_W'(1);
        end

        held_d = (state_d == LONG_HELD);
    end

    assign btn.short_press  = short_q;
    assign btn.long_press   = long_q;
    assign btn.double_click = dbl_q;
    assign btn.held         = held_q;
endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with TICK_DIV=4, LONG_MS=5, DCLICK_MS=3.
// Expected values follow the double-click window when BTN_DCLICK_EN is defined.
module tb_button_event_decoder;
`ifdef BTN_DCLICK_EN
    localparam bit DC = 1'b1;
`else
    localparam bit DC = 1'b0;
`endif

    logic clk;
    logic rst_n;
    button_event_decoder_if bus ();

    button_event_decoder #(
        .TICK_DIV (4),
        .LONG_MS  (5),
        .DCLICK_MS(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int idx, cnt_s, cnt_l, cnt_d, first_s, last_s, last_l, last_d, held_first, multi;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        idx = 0; cnt_s = 0; cnt_l = 0; cnt_d = 0;
        first_s = 0; last_s = 0; last_l = 0; last_d = 0; held_first = 0;
    endtask

    // Drive level for n edges, sampling outputs 1 time unit after each edge
    task automatic hold(input logic lv, input int n);
        for (int k = 0; k < n; k++) begin
            bus.level = lv;
            @(posedge clk);
            #1;
            idx++;
            if (bus.short_press === 1'b1) begin
                cnt_s++;
                if (first_s == 0) first_s = idx;
                last_s = idx;
            end
            if (bus.long_press === 1'b1) begin cnt_l++; last_l = idx; end
            if (bus.double_click === 1'b1) begin cnt_d++; last_d = idx; end
            if (bus.held === 1'b1 && held_first == 0) held_first = idx;
            if ((int'(bus.short_press) + int'(bus.long_press) + int'(bus.double_click)) > 1) multi++;
        end
    endtask

    initial begin
        multi     = 0;
        bus.level = 1'b1;
        rst_n     = 1'b0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", int'({bus.short_press, bus.long_press, bus.double_click, bus.held}), 0);
        rst_n = 1'b1;

        // Held through reset: stays locked out
        hold(1'b1, 40);
        chk("lockout_events", cnt_s + cnt_l + cnt_d, 0);
        chk("lockout_held", int'(bus.held), 0);
        clr();
        hold(1'b0, 2);
        hold(1'b1, 6);
        hold(1'b0, 14);
        chk("s1_short_cnt", cnt_s, 1);
        chk("s1_short_at", last_s, DC ? 21 : 9);

        // Long press
        clr();
        hold(1'b1, 30);
        chk("s2_long_cnt", cnt_l, 1);
        chk("s2_long_at", last_l, 21);
        chk("s2_held_rise", held_first, 21);
        chk("s2_held_hi", int'(bus.held), 1);
        hold(1'b0, 1);
        chk("s2_held_fall", int'(bus.held), 0);
        hold(1'b0, 14);
        chk("s2_no_short", cnt_s, 0);

        // Release on the final tick edge
        clr();
        hold(1'b1, 20);
        hold(1'b0, 15);
        chk("s3_no_long", cnt_l, 0);
        chk("s3_short_cnt", cnt_s, 1);
        chk("s3_short_at", last_s, DC ? 33 : 21);

        // Double click (two short presses without the window)
        clr();
        hold(1'b1, 5);
        hold(1'b0, 6);
        hold(1'b1, 5);
        hold(1'b0, 15);
        chk("s4_dbl_cnt", cnt_d, DC ? 1 : 0);
        chk("s4_dbl_at", last_d, DC ? 12 : 0);
        chk("s4_short_cnt", cnt_s, DC ? 0 : 2);
        chk("s4_short_first", first_s, DC ? 0 : 6);
        chk("s4_short_last", last_s, DC ? 0 : 17);
        clr();
        hold(1'b1, 3);
        hold(1'b0, 14);
        chk("s4_idle_after", last_s, DC ? 16 : 4);

        // Gap timeout then a fresh press right after
        clr();
        hold(1'b1, 5);
        hold(1'b0, 13);
        hold(1'b1, 4);
        hold(1'b0, 14);
        chk("s5_dbl_cnt", cnt_d, 0);
        chk("s5_short_cnt", cnt_s, 2);
        chk("s5_short_first", first_s, DC ? 18 : 6);
        chk("s5_short_last", last_s, DC ? 35 : 23);

        // Long second press
        clr();
        hold(1'b1, 3);
        hold(1'b0, 2);
        hold(1'b1, 30);
        hold(1'b0, 15);
        chk("s6_dbl_cnt", cnt_d, DC ? 1 : 0);
        chk("s6_long_cnt", cnt_l, DC ? 0 : 1);
        chk("s6_long_at", last_l, DC ? 0 : 26);
        chk("s6_short_cnt", cnt_s, DC ? 0 : 1);

        // Reset while in the long hold, released with the button still down
        clr();
        hold(1'b1, 25);
        chk("r_held_pre", int'(bus.held), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_held_async", int'(bus.held), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        clr();
        hold(1'b1, 30);
        hold(1'b0, 15);
        chk("r_lock_events", cnt_s + cnt_l + cnt_d, 0);
        clr();
        hold(1'b1, 2);
        hold(1'b0, 14);
        chk("r_after_short", last_s, DC ? 15 : 3);

        chk("one_event_per_cycle", multi, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
